shader_regfile: RTL and testbench

Operand register file and scoreboard for the shader core ALU path. Sits directly upstream of the ALU: on each accepted issue it reads two source registers and presents them registered as `val_a`/`val_b`. It also sits downstream of the ALU: it accepts the ALU `result`/`nzp` as a writeback, updates the destination register and the condition-code register, and tracks outstanding destinations so that dependent issues stall.

---
 rtl/shader_regfile.sv | 125 ++++++++++++
 tb/tb_shader_regfile.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shader_regfile.sv
`default_nettype none
// ============================================================================
// Module   : shader_regfile
// Purpose  : Operand register file and scoreboard for the shader ALU path.
//            Reads two sources per accepted issue (registered, 1-cycle
//            latency, same-cycle writeback forwarding), accepts ALU
//            writebacks, keeps the condition code and tracks pending
//            destinations so that dependent issues stall.
// Ports    : clk, rst (async, active-high)
//            iss_valid/iss_src_a/iss_src_b/iss_dest -> iss_stall (comb)
//            rd_data_a/rd_data_b : registered operands for the ALU
//            wb_valid/wb_addr/wb_data/wb_nzp/wb_set_cc : writeback port
//            cc_nzp : condition code, busy : any claim pending,
//            wb_err : sticky "writeback to non-pending register"
// Revision : 1.0 - initial release
// ============================================================================
module shader_regfile #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_src_a,
  input  logic [AW-1:0]     iss_src_b,
  input  logic [AW-1:0]     iss_dest,
  output logic              iss_stall,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        wb_nzp,
  input  logic              wb_set_cc,
  output logic [2:0]        cc_nzp,
  output logic              busy,
  output logic              wb_err
);

  localparam logic [2:0] CC_RESET = 3'b010;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]   rd_a_q, rd_a_d;
  logic [DATA_W-1:0]   rd_b_q, rd_b_d;
  logic [2:0]          cc_q, cc_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                wb_wr;       // writeback that targets a real register
  logic [NUM_REGS-1:0] wb_clr;      // one-hot of the register being written
  logic [NUM_REGS-1:0] blocking;    // pending bits not released this cycle
  logic                accept;
  logic [DATA_W-1:0]   val_a, val_b;

  always_comb begin
    wb_wr  = wb_valid && (wb_addr != '0);
    wb_clr = '0;
    if (wb_wr) wb_clr[wb_addr] = 1'b1;
    // Register 0 is never set pending, so it can never block.
    blocking  = pending_q & ~wb_clr;
    iss_stall = iss_valid &&
                (blocking[iss_src_a] || blocking[iss_src_b] || blocking[iss_dest]);
    accept    = iss_valid && !iss_stall;

    // Operand fetch with same-cycle forwarding; r0 reads as zero.
    val_a = '0;
    if (iss_src_a != '0) val_a = (wb_wr && wb_addr == iss_src_a) ? wb_data : regs_q[iss_src_a];
    val_b = '0;
    if (iss_src_b != '0) val_b = (wb_wr && wb_addr == iss_src_b) ? wb_data : regs_q[iss_src_b];

    regs_d    = regs_q;
    pending_d = pending_q;
    rd_a_d    = rd_a_q;
    rd_b_d    = rd_b_q;
    cc_d      = cc_q;
    err_d     = err_q;

    if (wb_wr) begin
      regs_d[wb_addr]    = wb_data;
      pending_d[wb_addr] = 1'b0;
      if (!pending_q[wb_addr]) err_d = 1'b1;
    end
    if (wb_valid && wb_set_cc) cc_d = wb_nzp;

    if (accept) begin
      rd_a_d = val_a;
      rd_b_d = val_b;
      // Applied after the writeback clear: a new claim on the same register wins.
      if (iss_dest != '0) pending_d[iss_dest] = 1'b1;
    end

    busy_d = |pending_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      cc_q      <= CC_RESET;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      pending_q <= pending_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
      cc_q      <= cc_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign cc_nzp    = cc_q;
  assign busy      = busy_q;
  assign wb_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shader_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_shader_regfile
// Purpose  : Directed, table-driven self-checking bench for shader_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shader_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [2:0]  iss_src_a, iss_src_b, iss_dest;
  logic        iss_stall;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  wb_nzp;
  logic        wb_set_cc;
  logic [2:0]  cc_nzp;
  logic        busy, wb_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shader_regfile #(.NUM_REGS(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
    .iss_dest(iss_dest), .iss_stall(iss_stall),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_nzp(wb_nzp), .wb_set_cc(wb_set_cc),
    .cc_nzp(cc_nzp), .busy(busy), .wb_err(wb_err)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  sa, sb, de;
    logic        wv;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  wn;
    logic        wc;
    logic        e_stall;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_cc;
    logic        e_busy, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [2:0] sa, logic [2:0] sb, logic [2:0] de,
                              logic wv, logic [2:0] wa, logic [31:0] wd, logic [2:0] wn,
                              logic wc, logic e_stall, logic [31:0] e_a, logic [31:0] e_b,
                              logic [2:0] e_cc, logic e_busy, logic e_err);
    vec_t v;
    v.iv = iv; v.sa = sa; v.sb = sb; v.de = de;
    v.wv = wv; v.wa = wa; v.wd = wd; v.wn = wn; v.wc = wc;
    v.e_stall = e_stall; v.e_a = e_a; v.e_b = e_b;
    v.e_cc = e_cc; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    iss_valid = v.iv; iss_src_a = v.sa; iss_src_b = v.sb; iss_dest = v.de;
    wb_valid = v.wv; wb_addr = v.wa; wb_data = v.wd; wb_nzp = v.wn; wb_set_cc = v.wc;
  endtask

  // Drive at negedge, check the combinational stall, clock, check the flops.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk("iss_stall", idx, {31'd0, iss_stall}, {31'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk("rd_data_a", idx, rd_data_a, v.e_a);
    chk("rd_data_b", idx, rd_data_b, v.e_b);
    chk("cc_nzp",    idx, {29'd0, cc_nzp}, {29'd0, v.e_cc});
    chk("busy",      idx, {31'd0, busy},   {31'd0, v.e_busy});
    chk("wb_err",    idx, {31'd0, wb_err}, {31'd0, v.e_err});
  endtask

  initial begin
    //            iv sa sb de  wv wa wd            wn    wc  stall a             b             cc    busy err
    // basic issue / writeback / read-back
    vecs.push_back(mk(1, 0, 0, 2,  0, 0, 32'd0,        3'd0, 0,  0, 32'd0,        32'd0,        3'b010, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 2, 32'd7,        3'b001, 1, 0, 32'd0,       32'd0,        3'b001, 0, 0));
    vecs.push_back(mk(1, 2, 2, 0,  0, 0, 32'd0,        3'd0, 0,  0, 32'd7,        32'd7,        3'b001, 0, 0));
    // RAW stall on r4, released by same-cycle writeback with forwarding
    vecs.push_back(mk(1, 0, 0, 4,  0, 0, 32'd0,        3'd0, 0,  0, 32'd0,        32'd0,        3'b001, 1, 0));
    vecs.push_back(mk(1, 4, 2, 0,  0, 0, 32'd0,        3'd0, 0,  1, 32'd0,        32'd0,        3'b001, 1, 0));
    vecs.push_back(mk(1, 4, 2, 0,  0, 0, 32'd0,        3'd0, 0,  1, 32'd0,        32'd0,        3'b001, 1, 0));
    vecs.push_back(mk(1, 4, 2, 0,  0, 0, 32'd0,        3'd0, 0,  1, 32'd0,        32'd0,        3'b001, 1, 0));
    vecs.push_back(mk(1, 4, 2, 0,  1, 4, 32'hFFFF_FFFF, 3'b100, 0, 0, 32'hFFFF_FFFF, 32'd7,    3'b001, 0, 0));
    // same-address set/clear on r5
    vecs.push_back(mk(1, 0, 0, 5,  0, 0, 32'd0,        3'd0, 0,  0, 32'd0,        32'd0,        3'b001, 1, 0));
    vecs.push_back(mk(1, 0, 4, 5,  1, 5, 32'd9,        3'b010, 1, 0, 32'd0,       32'hFFFF_FFFF, 3'b010, 1, 0));
    vecs.push_back(mk(1, 5, 0, 0,  0, 0, 32'd0,        3'd0, 0,  1, 32'd0,        32'hFFFF_FFFF, 3'b010, 1, 0));
    vecs.push_back(mk(1, 0, 0, 5,  0, 0, 32'd0,        3'd0, 0,  1, 32'd0,        32'hFFFF_FFFF, 3'b010, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 5, 32'd9,        3'b001, 0, 0, 32'd0,       32'hFFFF_FFFF, 3'b010, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0,  0, 0, 32'd0,        3'd0, 0,  0, 32'd9,        32'd0,        3'b010, 0, 0));
    // register 0: write discarded, cc still updated, dest 0 never busy
    vecs.push_back(mk(1, 0, 0, 0,  1, 0, 32'd55,       3'b100, 1, 0, 32'd0,       32'd0,        3'b100, 0, 0));
    vecs.push_back(mk(1, 0, 2, 0,  0, 0, 32'd0,        3'd0, 0,  0, 32'd0,        32'd7,        3'b100, 0, 0));
    // error flag: writeback to non-pending r6, then sticky across traffic
    vecs.push_back(mk(0, 0, 0, 0,  1, 6, 32'd3,        3'b001, 0, 0, 32'd0,       32'd7,        3'b100, 0, 1));
    vecs.push_back(mk(1, 2, 4, 3,  0, 0, 32'd0,        3'd0, 0,  0, 32'd7,        32'hFFFF_FFFF, 3'b100, 1, 1));
    vecs.push_back(mk(1, 3, 6, 0,  1, 3, 32'd11,       3'b001, 1, 0, 32'd11,      32'd3,        3'b001, 0, 1));
    // claim r7 so that reset interrupts an outstanding claim
    vecs.push_back(mk(1, 0, 0, 7,  0, 0, 32'd0,        3'd0, 0,  0, 32'd0,        32'd0,        3'b001, 1, 1));

    iss_valid = 0; iss_src_a = 0; iss_src_b = 0; iss_dest = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; wb_nzp = 0; wb_set_cc = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data_a", -1, rd_data_a, 32'd0);
    chk("reset rd_data_b", -1, rd_data_b, 32'd0);
    chk("reset cc_nzp",    -1, {29'd0, cc_nzp}, 32'd2);
    chk("reset busy",      -1, {31'd0, busy},   32'd0);
    chk("reset wb_err",    -1, {31'd0, wb_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Mid-run asynchronous reset: outputs clear without a clock edge.
    @(negedge clk);
    iss_valid = 0; wb_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst rd_data_a", 100, rd_data_a, 32'd0);
    chk("midrst rd_data_b", 100, rd_data_b, 32'd0);
    chk("midrst cc_nzp",    100, {29'd0, cc_nzp}, 32'd2);
    chk("midrst busy",      100, {31'd0, busy},   32'd0);
    chk("midrst wb_err",    100, {31'd0, wb_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // r3 reads 0 after reset; a writeback for the pre-reset r7 claim is an error
    // (and is forwarded to the concurrent read of r7).
    apply(mk(1, 3, 7, 0,  1, 7, 32'd5, 3'b001, 0,  0, 32'd0, 32'd5, 3'b010, 0, 1), 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
